// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// HAZ_MASK stage bit positions and the legal branch-penalty range.
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BRANCH = 1'b1
  } hz_state_e;

  localparam int HAZ_EX_BIT  = 2;
  localparam int HAZ_MEM_BIT = 1;
  localparam int HAZ_WR_BIT  = 0;

  localparam int BR_PEN_MIN = 1;
  localparam int BR_PEN_MAX = 4;

  // Wide enough to hold BR_PEN_MAX-1.
  localparam int BR_LEFT_W = 3;

endpackage

// File: rtl/reg_match.sv
// Register-address comparator: fires when enabled, the source is not r0,
// and the source matches the destination.
module reg_match #(
  parameter int REG_AW = 5
) (
  input  logic              en,
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] dst,
  output logic              hit
);

  assign hit = en & (src != '0) & (src == dst);

endmodule

// File: rtl/hazard_ctrl.sv
// Data-hazard interlock and branch-penalty sequencer for a 5-stage pipeline,
// with saturating stall-cycle performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int         REG_AW     = 5,
  parameter logic [2:0] HAZ_MASK   = 3'b111,
  parameter int         BR_PENALTY = 2,
  parameter int         CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              ex_regwr,
  input  logic              mem_regwr,
  input  logic              wr_regwr,
  input  logic [REG_AW-1:0] ex_rw,
  input  logic [REG_AW-1:0] mem_rw,
  input  logic [REG_AW-1:0] wr_rw,
  output logic              if_stall,
  output logic              id_stall,
  output logic              id_bubble,
  output logic [CNT_W-1:0]  dstall_cnt,
  output logic [CNT_W-1:0]  bstall_cnt
);

  if (BR_PENALTY < BR_PEN_MIN || BR_PENALTY > BR_PEN_MAX) begin : g_bad_penalty
    $error("hazard_ctrl: BR_PENALTY out of range 1..4");
  end

  localparam logic [BR_LEFT_W-1:0] BR_RELOAD = BR_LEFT_W'(BR_PENALTY - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [REG_AW-1:0] src_reg [2];
  logic [1:0]        src_use;
  logic [REG_AW-1:0] st_rw   [3];
  logic [2:0]        st_regwr;
  logic [5:0]        hit;
  logic              dhaz;

  assign src_reg[0] = id_rs;
  assign src_reg[1] = id_rt;
  assign src_use    = {id_use_rt, id_use_rs};

  assign st_rw[HAZ_EX_BIT]     = ex_rw;
  assign st_rw[HAZ_MEM_BIT]    = mem_rw;
  assign st_rw[HAZ_WR_BIT]     = wr_rw;
  assign st_regwr[HAZ_EX_BIT]  = ex_regwr;
  assign st_regwr[HAZ_MEM_BIT] = mem_regwr;
  assign st_regwr[HAZ_WR_BIT]  = wr_regwr;

  // One comparator per (source, producing stage); masked stages are forwarded.
  for (genvar s = 0; s < 2; s++) begin : g_src
    for (genvar x = 0; x < 3; x++) begin : g_stage
      reg_match #(.REG_AW(REG_AW)) u_match (
        .en  (id_valid & src_use[s] & HAZ_MASK[x] & st_regwr[x]),
        .src (src_reg[s]),
        .dst (st_rw[x]),
        .hit (hit[s*3 + x])
      );
    end
  end

  assign dhaz = |hit;

  hz_state_e             state;
  logic [BR_LEFT_W-1:0]  br_left;
  logic                  br_start;
  logic                  br_term;

  // A branch only starts from RUN and only when no data hazard holds it back.
  assign br_start  = (state == ST_RUN) & id_branch & id_valid & ~dhaz;
  assign br_term   = br_start | (state == ST_BRANCH);
  assign if_stall  = dhaz | br_term;
  assign id_stall  = dhaz;
  assign id_bubble = dhaz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      br_left    <= '0;
      dstall_cnt <= '0;
      bstall_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (br_start && (BR_PENALTY > 1)) begin
            state   <= ST_BRANCH;
            br_left <= BR_RELOAD;
          end
        end
        ST_BRANCH: begin
          if (br_left <= BR_LEFT_W'(1)) begin
            state   <= ST_RUN;
            br_left <= '0;
          end else begin
            br_left <= br_left - 1'b1;
          end
        end
        default: begin
          state   <= ST_RUN;
          br_left <= '0;
        end
      endcase
      if (dhaz)    dstall_cnt <= sat_inc(dstall_cnt);
      if (br_term) bstall_cnt <= sat_inc(bstall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two parameterisations share one stimulus stream and
// are checked against a cycle-level reference model plus directed scenarios.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs, id_use_rt, id_branch;
  logic [4:0] id_rs, id_rt, ex_rw, mem_rw, wr_rw;
  logic       ex_regwr, mem_regwr, wr_regwr;

  logic        a_if_stall, a_id_stall, a_id_bubble;
  logic [15:0] a_dcnt, a_bcnt;
  logic        b_if_stall, b_id_stall, b_id_bubble;
  logic [3:0]  b_dcnt, b_bcnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .HAZ_MASK(3'b111), .BR_PENALTY(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
    .ex_regwr(ex_regwr), .mem_regwr(mem_regwr), .wr_regwr(wr_regwr),
    .ex_rw(ex_rw), .mem_rw(mem_rw), .wr_rw(wr_rw),
    .if_stall(a_if_stall), .id_stall(a_id_stall), .id_bubble(a_id_bubble),
    .dstall_cnt(a_dcnt), .bstall_cnt(a_bcnt));

  hazard_ctrl #(.REG_AW(5), .HAZ_MASK(3'b100), .BR_PENALTY(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
    .ex_regwr(ex_regwr), .mem_regwr(mem_regwr), .wr_regwr(wr_regwr),
    .ex_rw(ex_rw), .mem_rw(mem_rw), .wr_rw(wr_rw),
    .if_stall(b_if_stall), .id_stall(b_id_stall), .id_bubble(b_id_bubble),
    .dstall_cnt(b_dcnt), .bstall_cnt(b_bcnt));

  // Reference model: index 0 = dut_a, 1 = dut_b.
  logic [2:0] m_mask [2] = '{3'b111, 3'b100};
  int         m_pen  [2] = '{3, 2};
  int         m_max  [2] = '{65535, 15};
  int         m_rem  [2] = '{0, 0};
  int         m_dc   [2] = '{0, 0};
  int         m_bc   [2] = '{0, 0};

  function automatic bit m_dhaz(int k);
    logic [4:0] src [2];
    bit         use_ [2];
    logic [4:0] dst [3];
    bit         wr [3];
    src[0] = id_rs;  src[1] = id_rt;
    use_[0] = id_use_rs; use_[1] = id_use_rt;
    dst[2] = ex_rw;  dst[1] = mem_rw;  dst[0] = wr_rw;
    wr[2] = ex_regwr; wr[1] = mem_regwr; wr[0] = wr_regwr;
    m_dhaz = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 3; x++)
        if (id_valid && use_[s] && src[s] != 5'd0 && m_mask[k][x] && wr[x] && src[s] == dst[x])
          m_dhaz = 1'b1;
  endfunction

  function automatic bit m_brterm(int k);
    return (m_rem[k] > 0) || (id_branch && id_valid && !m_dhaz(k));
  endfunction

  task automatic tick();
    bit dh, bt;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      dh = m_dhaz(k);
      bt = m_brterm(k);
      if (reset) begin
        m_rem[k] = 0; m_dc[k] = 0; m_bc[k] = 0;
      end else begin
        if (dh && m_dc[k] < m_max[k]) m_dc[k]++;
        if (bt && m_bc[k] < m_max[k]) m_bc[k]++;
        if (m_rem[k] > 0) m_rem[k]--;
        else if (id_branch && id_valid && !dh) m_rem[k] = m_pen[k] - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_branch = 0;
    id_rs = 0; id_rt = 0; ex_rw = 0; mem_rw = 0; wr_rw = 0;
    ex_regwr = 0; mem_regwr = 0; wr_regwr = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    clr_inputs();
    reset = 1;
    @(negedge clk);
    tick(); tick(); tick();
    reset = 0;
    #1;
    n_tests++; if (a_dcnt !== 16'd0) begin n_fail++; $display("FAIL reset_a_dcnt got %0d exp 0", a_dcnt); end
    n_tests++; if (a_bcnt !== 16'd0) begin n_fail++; $display("FAIL reset_a_bcnt got %0d exp 0", a_bcnt); end
    n_tests++; if (b_dcnt !== 4'd0)  begin n_fail++; $display("FAIL reset_b_dcnt got %0d exp 0", b_dcnt); end
    n_tests++; if ({a_if_stall, a_id_stall, a_id_bubble} !== 3'b000)
      begin n_fail++; $display("FAIL reset_outs got %b exp 000", {a_if_stall, a_id_stall, a_id_bubble}); end
  endtask

  task automatic test_ex_hazard();
    id_valid = 1; id_use_rs = 1; id_rs = 5; ex_rw = 5; ex_regwr = 1;
    #1;
    n_tests++; if ({a_if_stall, a_id_stall, a_id_bubble} !== 3'b111)
      begin n_fail++; $display("FAIL ex_haz_outs got %b exp 111", {a_if_stall, a_id_stall, a_id_bubble}); end
    tick(); clr_inputs(); #1;
    n_tests++; if (a_dcnt !== 16'd1) begin n_fail++; $display("FAIL ex_haz_a_dcnt got %0d exp 1", a_dcnt); end
    n_tests++; if (b_dcnt !== 4'd1)  begin n_fail++; $display("FAIL ex_haz_b_dcnt got %0d exp 1", b_dcnt); end
    n_tests++; if (a_if_stall !== 1'b0) begin n_fail++; $display("FAIL ex_haz_clear got %b exp 0", a_if_stall); end
  endtask

  task automatic test_zero_reg();
    id_valid = 1; id_use_rt = 1; id_rt = 0; ex_rw = 0; ex_regwr = 1;
    #1;
    n_tests++; if ({a_if_stall, a_id_stall, a_id_bubble} !== 3'b000)
      begin n_fail++; $display("FAIL zero_reg_a got %b exp 000", {a_if_stall, a_id_stall, a_id_bubble}); end
    n_tests++; if (b_if_stall !== 1'b0) begin n_fail++; $display("FAIL zero_reg_b got %b exp 0", b_if_stall); end
    tick(); clr_inputs();
  endtask

  task automatic test_mask();
    id_valid = 1; id_use_rs = 1; id_rs = 7; mem_rw = 7; mem_regwr = 1;
    #1;
    n_tests++; if ({b_if_stall, b_id_stall} !== 2'b00)
      begin n_fail++; $display("FAIL mask_mem_b got %b exp 00", {b_if_stall, b_id_stall}); end
    n_tests++; if (a_if_stall !== 1'b1) begin n_fail++; $display("FAIL mask_mem_a got %b exp 1", a_if_stall); end
    tick();
    mem_regwr = 0; ex_rw = 7; ex_regwr = 1;
    #1;
    n_tests++; if ({b_if_stall, b_id_stall, b_id_bubble} !== 3'b111)
      begin n_fail++; $display("FAIL mask_ex_b got %b exp 111", {b_if_stall, b_id_stall, b_id_bubble}); end
    tick(); clr_inputs();
  endtask

  task automatic test_branch();
    bit exp_a [4] = '{1, 1, 1, 0};
    bit exp_b [4] = '{1, 1, 0, 0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin id_valid = 1; id_branch = 1; end
      else clr_inputs();
      #1;
      n_tests++; if (a_if_stall !== exp_a[c])
        begin n_fail++; $display("FAIL branch_a_c%0d got %b exp %b", c, a_if_stall, exp_a[c]); end
      n_tests++; if (b_if_stall !== exp_b[c])
        begin n_fail++; $display("FAIL branch_b_c%0d got %b exp %b", c, b_if_stall, exp_b[c]); end
      n_tests++; if (a_id_stall !== 1'b0)
        begin n_fail++; $display("FAIL branch_idstall_c%0d got %b exp 0", c, a_id_stall); end
      if (c < 3) tick();
    end
    n_tests++; if (a_bcnt !== 16'd3) begin n_fail++; $display("FAIL branch_a_bcnt got %0d exp 3", a_bcnt); end
    n_tests++; if (b_bcnt !== 4'd2)  begin n_fail++; $display("FAIL branch_b_bcnt got %0d exp 2", b_bcnt); end
    n_tests++; if (a_dcnt !== 16'd0) begin n_fail++; $display("FAIL branch_a_dcnt got %0d exp 0", a_dcnt); end
  endtask

  task automatic test_branch_after_hazard();
    bit exp_aif [6] = '{1, 1, 1, 1, 1, 0};
    bit exp_bif [6] = '{1, 1, 1, 1, 0, 0};
    bit exp_ids [6] = '{1, 1, 0, 0, 0, 0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      clr_inputs();
      if (c <= 2) begin id_valid = 1; id_branch = 1; end
      if (c <= 1) begin id_use_rs = 1; id_rs = 5; ex_rw = 5; ex_regwr = 1; end
      #1;
      n_tests++; if (a_if_stall !== exp_aif[c])
        begin n_fail++; $display("FAIL brhaz_a_if_c%0d got %b exp %b", c, a_if_stall, exp_aif[c]); end
      n_tests++; if (b_if_stall !== exp_bif[c])
        begin n_fail++; $display("FAIL brhaz_b_if_c%0d got %b exp %b", c, b_if_stall, exp_bif[c]); end
      n_tests++; if (a_id_stall !== exp_ids[c])
        begin n_fail++; $display("FAIL brhaz_ids_c%0d got %b exp %b", c, a_id_stall, exp_ids[c]); end
      if (c < 5) tick();
    end
    n_tests++; if (a_dcnt !== 16'd2) begin n_fail++; $display("FAIL brhaz_a_dcnt got %0d exp 2", a_dcnt); end
    n_tests++; if (a_bcnt !== 16'd3) begin n_fail++; $display("FAIL brhaz_a_bcnt got %0d exp 3", a_bcnt); end
    n_tests++; if (b_bcnt !== 4'd2)  begin n_fail++; $display("FAIL brhaz_b_bcnt got %0d exp 2", b_bcnt); end
    clr_inputs();
  endtask

  task automatic test_reset_mid_branch();
    do_reset();
    id_valid = 1; id_branch = 1;
    tick(); clr_inputs();
    reset = 1;
    #1;
    n_tests++; if (a_if_stall !== 1'b1) begin n_fail++; $display("FAIL midrst_hold got %b exp 1", a_if_stall); end
    tick(); reset = 0;
    #1;
    n_tests++; if (a_if_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_a_if got %b exp 0", a_if_stall); end
    n_tests++; if (b_if_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_b_if got %b exp 0", b_if_stall); end
    n_tests++; if ({a_dcnt, a_bcnt} !== 32'd0)
      begin n_fail++; $display("FAIL midrst_a_cnts got %0d/%0d exp 0/0", a_dcnt, a_bcnt); end
    n_tests++; if (b_bcnt !== 4'd0) begin n_fail++; $display("FAIL midrst_b_bcnt got %0d exp 0", b_bcnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    id_valid = 1; id_use_rs = 1; id_rs = 9; ex_rw = 9; ex_regwr = 1;
    for (int c = 0; c < 20; c++) tick();
    clr_inputs();
    #1;
    n_tests++; if (b_dcnt !== 4'd15)  begin n_fail++; $display("FAIL sat_b_dcnt got %0d exp 15", b_dcnt); end
    n_tests++; if (a_dcnt !== 16'd20) begin n_fail++; $display("FAIL sat_a_dcnt got %0d exp 20", a_dcnt); end
  endtask

  task automatic test_random();
    logic [2:0] exp_a, exp_b;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom % 50) == 0;
      id_valid  = ($urandom % 4) != 0;
      id_rs     = 5'($urandom % 4);
      id_rt     = 5'($urandom % 4);
      id_use_rs = 1'($urandom);
      id_use_rt = 1'($urandom);
      id_branch = ($urandom % 6) == 0;
      ex_regwr  = 1'($urandom);
      mem_regwr = 1'($urandom);
      wr_regwr  = 1'($urandom);
      ex_rw     = 5'($urandom % 4);
      mem_rw    = 5'($urandom % 4);
      wr_rw     = 5'($urandom % 4);
      #1;
      exp_a = {m_dhaz(0) | m_brterm(0), m_dhaz(0), m_dhaz(0)};
      exp_b = {m_dhaz(1) | m_brterm(1), m_dhaz(1), m_dhaz(1)};
      n_tests++; if ({a_if_stall, a_id_stall, a_id_bubble} !== exp_a)
        begin n_fail++; $display("FAIL rand_a_outs i=%0d got %b exp %b", i, {a_if_stall, a_id_stall, a_id_bubble}, exp_a); end
      n_tests++; if ({b_if_stall, b_id_stall, b_id_bubble} !== exp_b)
        begin n_fail++; $display("FAIL rand_b_outs i=%0d got %b exp %b", i, {b_if_stall, b_id_stall, b_id_bubble}, exp_b); end
      n_tests++; if ({a_dcnt, a_bcnt} !== {16'(m_dc[0]), 16'(m_bc[0])})
        begin n_fail++; $display("FAIL rand_a_cnts i=%0d got %0d/%0d exp %0d/%0d", i, a_dcnt, a_bcnt, m_dc[0], m_bc[0]); end
      n_tests++; if ({b_dcnt, b_bcnt} !== {4'(m_dc[1]), 4'(m_bc[1])})
        begin n_fail++; $display("FAIL rand_b_cnts i=%0d got %0d/%0d exp %0d/%0d", i, b_dcnt, b_bcnt, m_dc[1], m_bc[1]); end
      tick();
    end
    reset = 0;
    clr_inputs();
  endtask

  initial begin
    test_reset();
    test_ex_hazard();
    test_zero_reg();
    test_mask();
    test_branch();
    test_branch_after_hazard();
    test_reset_mid_branch();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter HAZ_MASK, default 3'b111: per-stage hazard enable, bit2=EX, bit1=MEM, bit0=WR; a cleared bit means that stage is forwarded and never stalls.
REQ-003 Parameter BR_PENALTY, default 2, legal 1..4: total IF-stall cycles per branch.
REQ-004 Parameter CNT_W, default 16: performance-counter width.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 id_valid  in  1  the ID stage holds a real instruction.
REQ-009 id_rs, id_rt  in  REG_AW  ID source registers.
REQ-010 id_use_rs, id_use_rt  in  1  the instruction reads that source.
REQ-011 id_branch  in  1  the ID instruction is beq, bne or bgtz.
REQ-012 ex_regwr, mem_regwr, wr_regwr  in  1  the stage will write the register file.
REQ-013 ex_rw, mem_rw, wr_rw  in  REG_AW  the stage destination register.
REQ-014 if_stall  out  1  hold the PC and IF/ID register.
REQ-015 id_stall  out  1  hold the ID stage.
REQ-016 id_bubble  out  1  inject a NOP into ID/EX.
REQ-017 dstall_cnt, bstall_cnt  out  CNT_W  saturating counts of data-stall and branch-stall cycles.

Function
REQ-018 Per source s in {rs, rt} and enabled stage X: hit = id_valid & id_use_s & (id_s != 0) & X_regwr & (id_s == X_rw).
REQ-019 dhaz is the OR of all hits; register 0 never causes a hazard.
REQ-020 dhaz drives if_stall, id_stall and id_bubble combinationally in the same cycle, with zero latency.
REQ-021 FSM states: RUN, BRANCH.
REQ-022 In RUN, id_branch & id_valid & !dhaz asserts if_stall in that cycle. If BR_PENALTY>1, the FSM goes to BRANCH and loads br_left = BR_PENALTY-1.
REQ-023 In BRANCH, if_stall stays asserted and br_left decrements each cycle. When br_left reaches 1, the FSM returns to RUN on the next edge.
REQ-024 In BRANCH, id_stall and id_bubble follow dhaz only. A new id_branch is ignored until RUN.
REQ-025 If dhaz and id_branch coincide, dhaz wins and the branch is evaluated again once dhaz clears.
REQ-026 if_stall = dhaz | branch-stall term. A branch in ID stalls IF for exactly BR_PENALTY consecutive cycles.
REQ-027 dstall_cnt increments on each cycle with dhaz = 1 and bstall_cnt on each cycle with a branch-stall term = 1. Both hold at 2^CNT_W-1.

Reset
REQ-028 While reset = 1: state = RUN, br_left = 0, counters = 0. Combinational outputs still reflect dhaz.
REQ-029 Reset in the middle of BRANCH aborts the remaining penalty; if_stall is low on the next cycle unless a new hazard or branch is present.

Structure
REQ-030 A shared package holds the FSM state enum, the HAZ_MASK bit-index constants and the BR_PENALTY legal bounds.
REQ-031 One sub-module, reg_match (REG_AW-wide equality with zero-exclusion and enable), is instantiated six times.
REQ-032 An out-of-range BR_PENALTY fails elaboration.

Verification
REQ-033 id_rs=5 used, ex_rw=5, ex_regwr=1 -> if_stall=id_stall=id_bubble=1 in the same cycle; dstall_cnt +1.
REQ-034 id_rt=0 used, ex_rw=0, ex_regwr=1 -> no stall.
REQ-035 HAZ_MASK=3'b100, id_rs=7, mem_rw=7, mem_regwr=1 -> no stall; same operands at the EX stage -> stall.
REQ-036 BR_PENALTY=3, a single id_branch pulse -> if_stall high for exactly 3 cycles; bstall_cnt=3.
REQ-037 id_branch with an EX hazard for 2 cycles -> 2 data-stall cycles, then BR_PENALTY branch-stall cycles.
REQ-038 Reset asserted in the 2nd BRANCH cycle -> the next cycle has state RUN, if_stall=0, both counters 0.
REQ-039 CNT_W=4 with a 20-cycle hazard -> dstall_cnt saturates at 15.
